// File: rtl/mem_ldst_unit.sv
// MEM-stage load/store unit: runs a req/ack handshake with data memory,
// lane-steers byte/halfword stores, and sign/zero-extends loads.
// Optional build macro: LDST_TIMEOUT_EN adds a request timeout (TIMEOUT_CYC)
// that aborts with a one-cycle o_con_buserr pulse.
module mem_ldst_unit #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_con_memread,
    input  logic        i_con_memwrite,
    input  logic [1:0]  i_con_size,
    input  logic        i_con_unsigned,
    input  logic [31:0] i_data_addrM,
    input  logic [31:0] i_data_writeM,
    output logic        o_con_stall,
    output logic        o_con_misalign,
    output logic        o_con_buserr,
    output logic [31:0] o_data_readM,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // The timeout counter is 8 bits wide; an out-of-range limit elaborates
    // this marker block so it is easy to spot in the hierarchy.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_timeout_cyc_out_of_range
    end

    logic [1:0]  state_q, state_d;
    logic [29:0] addr_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] rdata_q;

    logic        access;
    logic        misalign;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] load_fmt;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        timeout;

    assign access = i_con_memread | i_con_memwrite;

    // Store lane steering and alignment check on the incoming access.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        be_d     = 4'b1111;
        wdata_d  = i_data_writeM;
        misalign = 1'b0;
        case (i_con_size)
            2'b00: begin
                be_d    = 4'b0001 << i_data_addrM[1:0];
                wdata_d = {4{i_data_writeM[7:0]}};
            end
            2'b01: begin
                be_d     = i_data_addrM[1] ? 4'b1100 : 4'b0011;
                wdata_d  = {2{i_data_writeM[15:0]}};
                misalign = i_data_addrM[0];
            end
            default: begin
                misalign = |i_data_addrM[1:0];
            end
        endcase
    end

    // Extract and extend the addressed lane of the returned word.
    always_comb begin
        byte_sel = i_mem_rdata[{lane_q, 3'b000} +: 8];
        half_sel = i_mem_rdata[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_fmt = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_fmt = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_fmt = i_mem_rdata;
        endcase
        if (we_q) begin
            load_fmt = 32'b0;
        end
    end

`ifdef LDST_TIMEOUT_EN
    localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT_CYC - 1);

    logic [7:0] cnt_q;
    logic       buserr_q;

    // The limit cycle is the TIMEOUT_CYC-th REQ cycle; an ack there wins.
    assign timeout      = (state_q == S_REQ) && !i_mem_ack && (cnt_q == CNT_LIMIT);
    assign o_con_buserr = buserr_q;

    // Wait counter runs only in REQ; buserr pulses in the DONE cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q    <= 8'd0;
            buserr_q <= 1'b0;
        end else begin
            buserr_q <= timeout;
            if (state_q != S_REQ) begin
                cnt_q <= 8'd0;
            end else if (!i_mem_ack) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end
`else
    assign timeout      = 1'b0;
    assign o_con_buserr = 1'b0;
`endif

    // Next-state logic: ack is only looked at in REQ, DONE always returns.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (access && !misalign) state_d = S_REQ;
            S_REQ:   if (i_mem_ack || timeout) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, captured request and load result.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            addr_q  <= 30'b0;
            lane_q  <= 2'b0;
            wdata_q <= 32'b0;
            be_q    <= 4'b0;
            we_q    <= 1'b0;
            size_q  <= 2'b0;
            uns_q   <= 1'b0;
            rdata_q <= 32'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && access && !misalign) begin
                addr_q  <= i_data_addrM[31:2];
                lane_q  <= i_data_addrM[1:0];
                wdata_q <= wdata_d;
                be_q    <= be_d;
                we_q    <= i_con_memwrite;
                size_q  <= i_con_size;
                uns_q   <= i_con_unsigned;
            end
            if (state_q == S_REQ && i_mem_ack) begin
                rdata_q <= load_fmt;
            end else if (timeout) begin
                rdata_q <= 32'b0;
            end
        end
    end

    // Reset gates the combinational IDLE paths so all outputs read 0.
    assign o_con_stall    = !i_rst && ((state_q == S_REQ) ||
                            (state_q == S_IDLE && access && !misalign));
    assign o_con_misalign = !i_rst && (state_q == S_IDLE) && access && misalign;
    assign o_mem_req      = (state_q == S_REQ);
    assign o_mem_we       = we_q;
    assign o_mem_addr     = {addr_q, 2'b00};
    assign o_mem_wdata    = wdata_q;
    assign o_mem_be       = be_q;
    assign o_data_readM   = rdata_q;

endmodule

// File: tb/tb_mem_ldst_unit.sv
// Self-checking bench for mem_ldst_unit: expected bus fields and load
// results are queued at launch and compared when the access completes.
module tb_mem_ldst_unit;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] readm;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_con_memread, i_con_memwrite, i_con_unsigned;
    logic [1:0]  i_con_size;
    logic [31:0] i_data_addrM, i_data_writeM;
    logic        o_con_stall, o_con_misalign, o_con_buserr;
    logic [31:0] o_data_readM;
    logic        o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

`ifdef LDST_TIMEOUT_EN
    localparam int RST_WAIT = 3;
`else
    localparam int RST_WAIT = 5;
`endif

    mem_ldst_unit #(.TIMEOUT_CYC(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_con_memread(i_con_memread), .i_con_memwrite(i_con_memwrite),
        .i_con_size(i_con_size), .i_con_unsigned(i_con_unsigned),
        .i_data_addrM(i_data_addrM), .i_data_writeM(i_data_writeM),
        .o_con_stall(o_con_stall), .o_con_misalign(o_con_misalign),
        .o_con_buserr(o_con_buserr), .o_data_readM(o_data_readM),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference behaviour for random accesses (aligned addresses only).
    function automatic exp_t model(input logic wr, input logic [1:0] sz, input logic uns,
                                   input logic [31:0] addr, wd, rdata);
        exp_t        e;
        logic [31:0] v;
        int          k;
        k       = int'(addr[1:0]);
        e.addr  = addr & 32'hFFFF_FFFC;
        e.we    = wr;
        if (sz == 2'b00) begin
            for (int i = 0; i < 4; i++) e.be[i] = (i == k);
            e.wdata = wd[7:0] * 32'h0101_0101;
            v = (rdata >> (8 * k)) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            e.be    = (k >= 2) ? 4'hC : 4'h3;
            e.wdata = wd[15:0] * 32'h0001_0001;
            v = (rdata >> (8 * k)) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            e.be    = 4'hF;
            e.wdata = wd;
            v       = rdata;
        end
        e.readm = wr ? 32'h0 : v;
        return e;
    endfunction

    task automatic idle_inputs();
        i_con_memread  = 1'b0;
        i_con_memwrite = 1'b0;
        i_con_size     = 2'b10;
        i_con_unsigned = 1'b0;
        i_data_addrM   = 32'h0;
        i_data_writeM  = 32'h0;
    endtask

    // Launch one access, ack it after `waits` REQ cycles, compare at DONE.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rdata, input int waits, input exp_t e);
        exp_t cur;
        int   n;
        int   stalls;
        sb.push_back(e);
        @(negedge i_clk);
        i_con_memread  = rd;
        i_con_memwrite = wr;
        i_con_size     = sz;
        i_con_unsigned = uns;
        i_data_addrM   = addr;
        i_data_writeM  = wd;
        i_mem_rdata    = rdata;
        #1;
        stalls = int'(o_con_stall);
        check("req_before_accept", 32'(o_mem_req), 32'd0);
        n = 0;
        @(negedge i_clk);
        while (o_mem_req === 1'b1 && n < 64) begin
            if (n == 0) begin
                cur = sb[0];
                check("mem_addr", o_mem_addr, cur.addr);
                check("mem_we", 32'(o_mem_we), 32'(cur.we));
                check("mem_be", 32'(o_mem_be), 32'(cur.be));
                if (cur.we) check("mem_wdata", o_mem_wdata, cur.wdata);
            end
            stalls += int'(o_con_stall);
            i_mem_ack = (n == waits);
            n++;
            @(negedge i_clk);
        end
        i_mem_ack = 1'b0;
        cur = sb.pop_front();
        check("req_cycles", 32'(n), 32'(waits + 1));
        check("stall_cycles", 32'(stalls), 32'(waits + 2));
        check("done_stall", 32'(o_con_stall), 32'd0);
        check("done_buserr", 32'(o_con_buserr), 32'd0);
        check("readM", o_data_readM, cur.readm);
        idle_inputs();
    endtask

    initial begin
        exp_t        e;
        logic [1:0]  sz;
        logic        rd, wr, uns;
        logic [31:0] addr, wd, rdata;
        int          n;

        i_rst       = 1'b1;
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'h0;
        idle_inputs();
        #12;
        check("rst_req", 32'(o_mem_req), 32'd0);
        check("rst_stall", 32'(o_con_stall), 32'd0);
        check("rst_readM", o_data_readM, 32'd0);
        check("rst_be", 32'(o_mem_be), 32'd0);
        check("rst_misalign", 32'(o_con_misalign), 32'd0);
        check("rst_buserr", 32'(o_con_buserr), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Word load, zero-wait memory.
        e = '{addr: 32'h100, we: 1'b0, be: 4'hF, wdata: 32'h0, readm: 32'h1234_5678};
        run_access(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'h1234_5678, 0, e);
        // lb / lbu at lane 3.
        e = '{addr: 32'h100, we: 1'b0, be: 4'h8, wdata: 32'h0, readm: 32'hFFFF_FF80};
        run_access(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80FF_FF7F, 0, e);
        e.readm = 32'h0000_0080;
        run_access(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80FF_FF7F, 1, e);
        // sh to upper half.
        e = '{addr: 32'h200, we: 1'b1, be: 4'hC, wdata: 32'hABCD_ABCD, readm: 32'h0};
        run_access(0, 1, 2'b01, 0, 32'h202, 32'h0000_ABCD, 32'hFFFF_FFFF, 0, e);
        // lh upper half, sign-extended, two wait cycles.
        e = '{addr: 32'h100, we: 1'b0, be: 4'hC, wdata: 32'h0, readm: 32'hFFFF_8001};
        run_access(1, 0, 2'b01, 0, 32'h102, 32'h0, 32'h8001_7FFF, 2, e);
        // memread and memwrite together behave as a store.
        e = '{addr: 32'h300, we: 1'b1, be: 4'hF, wdata: 32'h5555_AAAA, readm: 32'h0};
        run_access(1, 1, 2'b10, 0, 32'h300, 32'h5555_AAAA, 32'h1111_2222, 0, e);

        // Misaligned word load: pulse only, no request, no stall.
        @(negedge i_clk);
        i_con_memread = 1'b1;
        i_con_size    = 2'b10;
        i_data_addrM  = 32'h101;
        #1;
        check("misalign_pulse", 32'(o_con_misalign), 32'd1);
        check("misalign_stall", 32'(o_con_stall), 32'd0);
        @(negedge i_clk);
        check("misalign_no_req", 32'(o_mem_req), 32'd0);
        idle_inputs();
        #1;
        check("misalign_clear", 32'(o_con_misalign), 32'd0);
        e = '{addr: 32'h104, we: 1'b0, be: 4'hF, wdata: 32'h0, readm: 32'h0BAD_F00D};
        run_access(1, 0, 2'b10, 0, 32'h104, 32'h0, 32'h0BAD_F00D, 0, e);

        // Random aligned accesses, model-predicted.
        for (int i = 0; i < 16; i++) begin
            sz    = 2'($urandom_range(0, 2));
            rd    = 1'($urandom_range(0, 1));
            wr    = ~rd;
            uns   = 1'($urandom_range(0, 1));
            addr  = $urandom;
            if (sz == 2'b01) addr[0] = 1'b0;
            if (sz == 2'b10) addr[1:0] = 2'b00;
            wd    = $urandom;
            rdata = $urandom;
            e = model(wr, sz, uns, addr, wd, rdata);
            run_access(rd, wr, sz, uns, addr, wd, rdata, int'($urandom_range(0, 3)), e);
        end

        // Reset mid-REQ: request drops at once, later ack is ignored.
        @(negedge i_clk);
        i_con_memread = 1'b1;
        i_data_addrM  = 32'h500;
        for (int i = 0; i <= RST_WAIT; i++) @(negedge i_clk);
        check("pre_rst_req", 32'(o_mem_req), 32'd1);
        #2;
        i_rst = 1'b1;
        #1;
        check("async_rst_req", 32'(o_mem_req), 32'd0);
        check("async_rst_stall", 32'(o_con_stall), 32'd0);
        check("async_rst_readM", o_data_readM, 32'd0);
        idle_inputs();
        @(negedge i_clk);
        i_rst       = 1'b0;
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'hDEAD_BEEF;
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        check("late_ack_req", 32'(o_mem_req), 32'd0);
        check("late_ack_readM", o_data_readM, 32'd0);
        check("late_ack_stall", 32'(o_con_stall), 32'd0);
        e = '{addr: 32'h600, we: 1'b0, be: 4'h3, wdata: 32'h0, readm: 32'h0000_8765};
        run_access(1, 0, 2'b01, 1, 32'h600, 32'h0, 32'hFFFF_8765, 1, e);

`ifdef LDST_TIMEOUT_EN
        // No ack: abort after the 4th REQ cycle.
        @(negedge i_clk);
        i_con_memread = 1'b1;
        i_data_addrM  = 32'h700;
        @(negedge i_clk);
        n = 0;
        while (o_mem_req === 1'b1 && n < 64) begin
            n++;
            @(negedge i_clk);
        end
        check("timeout_req_cycles", 32'(n), 32'd4);
        check("timeout_buserr", 32'(o_con_buserr), 32'd1);
        check("timeout_readM", o_data_readM, 32'd0);
        check("timeout_stall", 32'(o_con_stall), 32'd0);
        idle_inputs();
        @(negedge i_clk);
        check("timeout_buserr_pulse", 32'(o_con_buserr), 32'd0);
        // Ack in the limit cycle wins.
        e = '{addr: 32'h700, we: 1'b0, be: 4'hF, wdata: 32'h0, readm: 32'hCAFE_F00D};
        run_access(1, 0, 2'b10, 0, 32'h700, 32'h0, 32'hCAFE_F00D, 3, e);
`else
        n = 0;
        check("buserr_tied", 32'(o_con_buserr), 32'(n));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
